// File: rtl/net_seq_pkg.sv
// Shared state encoding and output saturation helper for the conv1d layer sequencer.
package net_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SHIFT  = 3'd1;
  localparam state_t ST_LRST   = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_CACHE  = 3'd4;
  localparam state_t ST_OUTPUT = 3'd5;

  // Left-shift a sign-extended value and clamp it to a signed range of 'width' bits.
  function automatic logic signed [31:0] sat_shl(input logic signed [31:0] value,
                                                 input int shift,
                                                 input int width);
    logic signed [63:0] ext;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    ext = {{32{value[31]}}, value};
    ext = ext <<< shift;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (ext > hi) begin
      return hi[31:0];
    end else if (ext < lo) begin
      return lo[31:0];
    end
    return ext[31:0];
  endfunction

endpackage

// File: rtl/sample_edge_detect.sv
// Rising-edge detector for a clk-synchronous sample strobe; one registered stage.
module sample_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/network_sequencer.sv
// Sequencer for the multi-layer conv1d chain: input pre-scale, per-layer reset/run/cache
// handshakes, watchdog, overrun counting and saturated output publication.
module network_sequencer
  import net_seq_pkg::*;
#(
  parameter int W          = 16,
  parameter int D          = 8,
  parameter int NUM_IN     = 4,
  parameter int NUM_LAYERS = 4,
  parameter int IN_SHIFT   = 2,
  parameter int OUT_SHIFT  = 2,
  parameter logic [NUM_IN-1:0] CH_EN = 4'b0001,
  parameter int TIMEOUT    = 1024,
  localparam int CW        = (NUM_LAYERS > 1) ? NUM_LAYERS - 1 : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_clk,
  input  logic [NUM_IN*W-1:0]   sample_in,
  output logic [NUM_IN*W-1:0]   shifted_in,
  output logic                  lsb_clk,
  output logic [NUM_LAYERS-1:0] layer_rst,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [CW-1:0]         cache_clk,
  input  logic [D*W-1:0]        final_out,
  output logic [NUM_IN*W-1:0]   sample_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic [7:0]            overrun_cnt,
  output logic                  timeout_err
);

  localparam int LI_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LI_W-1:0] LI_LAST = LI_W'(NUM_LAYERS - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT > 0);

  state_t                state_q, state_d;
  logic [LI_W-1:0]       li_q, li_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [NUM_IN*W-1:0]   shifted_q, shifted_d;
  logic [NUM_IN*W-1:0]   sample_q, sample_d;
  logic [7:0]            ovr_q, ovr_d;
  logic                  terr_q, terr_d;

  logic                  rise;
  logic                  accept;
  logic                  done_cur;
  logic [NUM_LAYERS-1:0] done_vec;
  logic [NUM_IN*W-1:0]   scaled;
  logic [NUM_IN*W-1:0]   sat_vec;
  logic signed [W-1:0]   in_el;
  logic signed [W-1:0]   out_el;

  // Channels NUM_IN..D-1 of final_out are deliberately not published.
  logic unused_final;
  assign unused_final = ^final_out;

  sample_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (sample_clk),
    .rise (rise)
  );

  assign accept   = rise && (state_q == ST_IDLE || state_q == ST_OUTPUT);
  assign done_vec = layer_done >> li_q;
  assign done_cur = done_vec[0];

  always_comb begin
    scaled  = '0;
    sat_vec = '0;
    in_el   = '0;
    out_el  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      in_el = sample_in[(NUM_IN-k)*W-1 -: W];
      if (CH_EN[k]) begin
        scaled[(NUM_IN-k)*W-1 -: W] = in_el >>> IN_SHIFT;
      end
      out_el = final_out[(D-k)*W-1 -: W];
      sat_vec[(NUM_IN-k)*W-1 -: W] = W'(sat_shl(32'(out_el), OUT_SHIFT, W));
    end
  end

  always_comb begin
    state_d   = state_q;
    li_d      = li_q;
    wd_d      = wd_q;
    shifted_d = shifted_q;
    sample_d  = sample_q;
    ovr_d     = ovr_q;
    terr_d    = terr_q;

    // Edges arriving mid-sequence are dropped but counted; the sequence itself carries on.
    if (rise && !accept && ovr_q != 8'hFF) begin
      ovr_d = ovr_q + 8'd1;
    end

    case (state_q)
      ST_IDLE, ST_OUTPUT: state_d = ST_IDLE;
      ST_SHIFT:           state_d = ST_LRST;
      ST_LRST: begin
        wd_d    = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (done_cur) begin
          if (li_q == LI_LAST) begin
            sample_d = sat_vec;
            state_d  = ST_OUTPUT;
          end else begin
            state_d = ST_CACHE;
          end
        end else if (WD_EN && wd_q == WD_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_CACHE: begin
        li_d    = li_q + LI_W'(1);
        state_d = ST_LRST;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      shifted_d = scaled;
      li_d      = '0;
      state_d   = ST_SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      li_q      <= '0;
      wd_q      <= '0;
      shifted_q <= '0;
      sample_q  <= '0;
      ovr_q     <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      li_q      <= li_d;
      wd_q      <= wd_d;
      shifted_q <= shifted_d;
      sample_q  <= sample_d;
      ovr_q     <= ovr_d;
      terr_q    <= terr_d;
    end
  end

  // Strobes decode straight from the state register.
  assign lsb_clk     = (state_q == ST_SHIFT);
  assign out_valid   = (state_q == ST_OUTPUT);
  assign busy        = (state_q != ST_IDLE);
  assign layer_rst   = (state_q == ST_LRST)  ? (NUM_LAYERS'(1) << li_q) : '0;
  assign cache_clk   = (state_q == ST_CACHE) ? (CW'(1) << li_q) : '0;
  assign shifted_in  = shifted_q;
  assign sample_out  = sample_q;
  assign overrun_cnt = ovr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_network_sequencer.sv
// Scoreboard bench: a single-layer instance (watchdog 16) and a four-layer instance.
module tb_network_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a, rst_b, sc_a, sc_b;
  logic [63:0]   sin_a, sin_b, shin_a, shin_b, sout_a, sout_b;
  logic          lsb_a, lsb_b, ov_a, ov_b, busy_a, busy_b, terr_a, terr_b;
  logic [0:0]    lrst_a, cclk_a;
  logic [0:0]    ldone_a = 1'b0;
  logic [3:0]    lrst_b, ldone_b;
  logic [2:0]    cclk_b;
  logic [127:0]  fin_a, fin_b;
  logic [7:0]    ovr_a, ovr_b;
  logic          en_done_a, hold_b;

  network_sequencer #(.W(16), .D(8), .NUM_IN(4), .NUM_LAYERS(1), .IN_SHIFT(2),
                      .OUT_SHIFT(2), .CH_EN(4'b0001), .TIMEOUT(16)) u_dut_a (
    .clk(clk), .rst(rst_a), .sample_clk(sc_a), .sample_in(sin_a), .shifted_in(shin_a),
    .lsb_clk(lsb_a), .layer_rst(lrst_a), .layer_done(ldone_a), .cache_clk(cclk_a),
    .final_out(fin_a), .sample_out(sout_a), .out_valid(ov_a), .busy(busy_a),
    .overrun_cnt(ovr_a), .timeout_err(terr_a)
  );

  network_sequencer #(.W(16), .D(8), .NUM_IN(4), .NUM_LAYERS(4), .IN_SHIFT(2),
                      .OUT_SHIFT(2), .CH_EN(4'b0101), .TIMEOUT(1024)) u_dut_b (
    .clk(clk), .rst(rst_b), .sample_clk(sc_b), .sample_in(sin_b), .shifted_in(shin_b),
    .lsb_clk(lsb_b), .layer_rst(lrst_b), .layer_done(ldone_b), .cache_clk(cclk_b),
    .final_out(fin_b), .sample_out(sout_b), .out_valid(ov_b), .busy(busy_b),
    .overrun_cnt(ovr_b), .timeout_err(terr_b)
  );

  // Layer models: A echoes layer_rst one cycle later; B finishes 5 cycles after layer_rst.
  always @(posedge clk) ldone_a <= en_done_a ? lrst_a : 1'b0;

  logic [4:0][3:0] pipe_b  = '0;
  logic [3:0]      ready_b = '0;
  always @(posedge clk) begin
    pipe_b[0] <= lrst_b;
    for (int j = 1; j < 5; j++) pipe_b[j] <= pipe_b[j-1];
    ready_b <= (ready_b | pipe_b[4]) & ~lrst_b;
  end
  assign ldone_b = hold_b ? 4'b0 : (ready_b | pipe_b[4]);

  int          n_checks = 0;
  int          n_err = 0;
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  int          evlog[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_out(input logic [127:0] f);
    logic [63:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      v = int'($signed(f[(8-k)*16-1 -: 16])) * 4;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      r[(4-k)*16-1 -: 16] = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [63:0] model_shift(input logic [63:0] s, input logic [3:0] en);
    logic [63:0] r;
    int v;
    int t;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      v = int'($signed(s[(4-k)*16-1 -: 16]));
      t = v >>> 2;
      r[(4-k)*16-1 -: 16] = en[k] ? t[15:0] : 16'h0;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (ov_a === 1'b1) begin
      if (exp_a.size() == 0) check("a_spurious_valid", 64'(exp_a.size()), 64'd1);
      else check("a_sample_out", sout_a, exp_a.pop_front());
    end
    for (int i = 0; i < 4; i++) if (lrst_b[i] === 1'b1) evlog.push_back(i);
    for (int i = 0; i < 3; i++) if (cclk_b[i] === 1'b1) evlog.push_back(10 + i);
    if (ov_b === 1'b1) begin
      evlog.push_back(20);
      if (exp_b.size() == 0) check("b_spurious_valid", 64'(exp_b.size()), 64'd1);
      else check("b_sample_out", sout_b, exp_b.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic edge_a();
    sc_a = 1'b1;
    tick(1);
    sc_a = 1'b0;
  endtask

  task automatic edge_b();
    sc_b = 1'b1;
    tick(1);
    sc_b = 1'b0;
  endtask

  task automatic wait_idle_b();
    int n;
    n = 0;
    while (busy_b && n < 200) begin
      tick(1);
      n++;
    end
    check("b_idle_bound", busy_b, 1'b0);
  endtask

  task automatic check_seq(input string tag);
    int exp_seq[8];
    exp_seq = '{0, 10, 1, 11, 2, 12, 3, 20};
    check({tag, "_len"}, 64'(evlog.size()), 64'd8);
    for (int i = 0; i < 8 && i < evlog.size(); i++) check({tag, "_ev"}, evlog[i], exp_seq[i]);
  endtask

  logic [15:0] sat_in[3];
  logic [15:0] sat_exp[3];
  logic [63:0] held;
  int          cyc;
  int          nv;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    sat_in  = '{16'h3000, 16'hC000, 16'hF000};
    sat_exp = '{16'h7FFF, 16'h8000, 16'hC000};
    rst_a = 1'b1; rst_b = 1'b1; sc_a = 1'b0; sc_b = 1'b0;
    en_done_a = 1'b1; hold_b = 1'b0;
    sin_a = '0; sin_b = '0; fin_a = '0; fin_b = '0;
    tick(3);
    rst_a = 1'b0; rst_b = 1'b0;
    tick(1);
    check("a_rst_busy", busy_a, 1'b0);
    check("a_rst_sout", sout_a, 64'h0);
    check("a_rst_shin", shin_a, 64'h0);
    check("b_rst_ovr", ovr_b, 8'h0);
    check("b_rst_terr", terr_b, 1'b0);
    check("b_rst_strobes", {lrst_b, cclk_b, lsb_b, ov_b}, 64'h0);

    // Single layer: latency and input pre-scale.
    sin_a = {16'h0400, 16'h1234, 16'hF000, 16'h8000};
    fin_a = {16'h0100, 112'h0};
    exp_a.push_back(model_out(fin_a));
    edge_a();
    check("a_lsb_e1", lsb_a, 1'b1);
    check("a_shin_e1", shin_a, model_shift(sin_a, 4'b0001));
    check("a_shin_ch0", shin_a[63:48], 16'h0100);
    tick(1);
    check("a_lrst_e2", lrst_a, 1'b1);
    tick(2);
    check("a_ovalid_e4", ov_a, 1'b1);
    check("a_sout_e4", sout_a, 64'h0400_0000_0000_0000);
    tick(1);
    check("a_idle_e5", busy_a, 1'b0);

    // Edge accepted in the OUTPUT cycle restarts immediately.
    exp_a.push_back(model_out(fin_a));
    exp_a.push_back(model_out(fin_a));
    edge_a();
    tick(3);
    check("a_b2b_ovalid", ov_a, 1'b1);
    sc_a = 1'b1;
    tick(1);
    sc_a = 1'b0;
    check("a_b2b_shift", lsb_a, 1'b1);
    tick(5);
    check("a_b2b_no_ovr", ovr_a, 8'h0);

    // Saturation boundaries.
    for (int i = 0; i < 3; i++) begin
      fin_a = {sat_in[i], 16'h1FFF, 16'hE000, 16'(16'h2000 + i), $urandom, $urandom};
      exp_a.push_back(model_out(fin_a));
      edge_a();
      tick(5);
      check("a_sat_ch0", sout_a[63:48], sat_exp[i]);
    end

    // Watchdog: layer never completes.
    check("a_terr_pre", terr_a, 1'b0);
    en_done_a = 1'b0;
    held = sout_a;
    edge_a();
    cyc = 1;
    while (busy_a && cyc < 100) begin
      tick(1);
      cyc++;
    end
    check("a_wd_idle_cycle", 64'(cyc), 64'd19);
    check("a_wd_terr", terr_a, 1'b1);
    check("a_wd_sout_held", sout_a, held);
    en_done_a = 1'b1;
    fin_a = {16'hFF00, 16'h0010, 16'h8000, 16'h7FFF, 64'h0};
    exp_a.push_back(model_out(fin_a));
    edge_a();
    tick(6);
    check("a_wd_sticky", terr_a, 1'b1);

    // Four-layer ordering.
    evlog.delete();
    fin_b = {16'h0123, 16'hFEDC, 16'h4000, 16'h8001, 64'hDEAD_BEEF_0000_FFFF};
    sin_b = {16'h0400, 16'h8000, 16'hFFFC, 16'h7FFF};
    exp_b.push_back(model_out(fin_b));
    edge_b();
    check("b_shin", shin_b, model_shift(sin_b, 4'b0101));
    wait_idle_b();
    check_seq("b_seq");

    // Overrun while stalled in RUN.
    evlog.delete();
    hold_b = 1'b1;
    exp_b.push_back(model_out(fin_b));
    edge_b();
    tick(10);
    for (int i = 0; i < 3; i++) begin
      sc_b = 1'b1;
      tick(1);
      sc_b = 1'b0;
      tick(2);
    end
    check("b_ovr3", ovr_b, 8'd3);
    check("b_ovr_busy", busy_b, 1'b1);
    hold_b = 1'b0;
    wait_idle_b();
    check("b_ovr3_after", ovr_b, 8'd3);
    nv = 0;
    foreach (evlog[i]) if (evlog[i] == 20) nv++;
    check("b_ovr_single_valid", 64'(nv), 64'd1);
    check_seq("b_ovr_seq");

    hold_b = 1'b1;
    exp_b.push_back(model_out(fin_b));
    edge_b();
    tick(5);
    repeat (300) begin
      sc_b = 1'b1;
      tick(1);
      sc_b = 1'b0;
      tick(1);
    end
    check("b_ovr_sat", ovr_b, 8'd255);
    hold_b = 1'b0;
    wait_idle_b();
    check("b_no_timeout", terr_b, 1'b0);

    // Reset during RUN of layer 2.
    evlog.delete();
    exp_b.push_back(model_out(fin_b));
    edge_b();
    cyc = 0;
    while (lrst_b[2] !== 1'b1 && cyc < 100) begin
      tick(1);
      cyc++;
    end
    check("b_lrst2_seen", lrst_b[2], 1'b1);
    tick(2);
    rst_b = 1'b1;
    tick(1);
    rst_b = 1'b0;
    exp_b.delete();
    check("b_mrst_busy", busy_b, 1'b0);
    check("b_mrst_sout", sout_b, 64'h0);
    check("b_mrst_shin", shin_b, 64'h0);
    check("b_mrst_ovr", ovr_b, 8'h0);
    check("b_mrst_strobes", {lrst_b, cclk_b, lsb_b, ov_b, terr_b}, 64'h0);
    tick(8);
    evlog.delete();
    fin_b = {16'h1000, 16'hDFFF, 16'h0001, 16'hFFFF, 64'h0};
    exp_b.push_back(model_out(fin_b));
    edge_b();
    wait_idle_b();
    check_seq("b_post_rst");

    tick(3);
    check("a_sb_drained", 64'(exp_a.size()), 64'd0);
    check("b_sb_drained", 64'(exp_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
